cnn_dma_arbiter: RTL

Shares the single DMA engine between up to N_REQ CNN-side requesters: layer controller, filter/bias loader, pooling writer. It uses round-robin arbitration with a start/finish level handshake on both sides. The handshake is identical to the one the CNN controller already uses toward the DMA, so requesters connect unchanged. Read data from the DMA (5x5 window) is broadcast to all requesters and is not routed by this block; the owner qualifies it with its own finish.

---
 rtl/cnn_dma_arbiter_pkg.sv | 37 +++
 rtl/cnn_dma_arbiter_if.sv | 40 ++++
 rtl/cnn_dma_arbiter_rr_pick.sv | 27 ++
 rtl/cnn_dma_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/cnn_dma_arbiter_pkg.sv
// Shared types for the CNN-side DMA arbiter: transfer modes, request payload
// and FSM states.
package cnn_dma_pkg;

  localparam int unsigned DMA_ADDR_W = 16;
  localparam int unsigned DMA_DATA_W = 16;

  typedef enum logic [1:0] {
    DMA_RD_WIN    = 2'd0,
    DMA_WR_WORD   = 2'd1,
    DMA_RD_FILTER = 2'd2,
    DMA_RD_BIAS   = 2'd3
  } dma_mode_e;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_ADDR_W-1:0] offset;
    dma_mode_e             mode;
    logic [DMA_ADDR_W-1:0] filter_number;
    logic [DMA_DATA_W-1:0] wdata;
  } dma_req_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic int unsigned onehot_idx(input logic [7:0] v);
    onehot_idx = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) onehot_idx = i;
    end
  endfunction

endpackage

// File: rtl/cnn_dma_arbiter_if.sv
// Requester-side and DMA-side handshake bundle of the arbiter.
// master = requesters/DMA model, slave = arbiter.
interface cnn_dma_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = cnn_dma_pkg::DMA_ADDR_W,
  parameter int unsigned DATA_W = cnn_dma_pkg::DMA_DATA_W
);

  logic [N_REQ-1:0]             req_start;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][ADDR_W-1:0] req_offset;
  logic [N_REQ-1:0][1:0]        req_mode;
  logic [N_REQ-1:0][ADDR_W-1:0] req_filter_number;
  logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]             req_finish;
  logic [N_REQ-1:0]             grant;

  logic              dma_start;
  logic              dma_finish;
  logic [ADDR_W-1:0] dma_start_address;
  logic [ADDR_W-1:0] dma_offset;
  logic [ADDR_W-1:0] dma_filter_number;
  logic [1:0]        dma_read_write_filter_bias;
  logic [DATA_W-1:0] dma_input_data;

  modport master (
    output req_start, req_addr, req_offset, req_mode, req_filter_number,
           req_wdata, dma_finish,
    input  req_finish, grant, dma_start, dma_start_address, dma_offset,
           dma_filter_number, dma_read_write_filter_bias, dma_input_data
  );

  modport slave (
    input  req_start, req_addr, req_offset, req_mode, req_filter_number,
           req_wdata, dma_finish,
    output req_finish, grant, dma_start, dma_start_address, dma_offset,
           dma_filter_number, dma_read_write_filter_bias, dma_input_data
  );

endinterface

// File: rtl/cnn_dma_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick #(
  parameter int unsigned N      = 3,
  parameter int unsigned LAST_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]      i_req,
  input  logic [LAST_W-1:0] i_last,
  output logic [N-1:0]      o_gnt_c,
  output logic              o_valid_c
);

  int unsigned w_idx;

  always_comb begin
    o_gnt_c   = '0;
    o_valid_c = 1'b0;
    w_idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = (32'(i_last) + k) % N;
      if (!o_valid_c && i_req[LAST_W'(w_idx)]) begin
        o_gnt_c[LAST_W'(w_idx)] = 1'b1;
        o_valid_c               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_dma_arbiter.sv
// Shares one DMA engine among N_REQ requesters with round-robin arbitration
// and a level start/finish handshake on both sides.
module cnn_dma_arbiter
  import cnn_dma_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input logic              clk,
  input logic              reset,
  cnn_dma_arbiter_if.slave bus
);

  localparam int unsigned LAST_W = $clog2(N_REQ);

  arb_state_e         r_state;
  logic [LAST_W-1:0]  r_last;
  logic [LAST_W-1:0]  r_owner;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_req_finish;
  logic               r_dma_start;
  dma_req_t           r_req;

  logic [N_REQ-1:0]   w_gnt;
  logic               w_valid;
  logic [LAST_W-1:0]  w_idx;

  rr_pick #(.N(N_REQ), .LAST_W(LAST_W)) u_pick (
    .i_req     (bus.req_start),
    .i_last    (r_last),
    .o_gnt_c   (w_gnt),
    .o_valid_c (w_valid)
  );

  assign w_idx = LAST_W'(onehot_idx(8'(w_gnt)));

  // Arbitration FSM; fields are latched once at grant so the DMA sees them stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last       <= LAST_W'(N_REQ - 1);
      r_owner      <= '0;
      r_grant      <= '0;
      r_req_finish <= '0;
      r_dma_start  <= 1'b0;
      r_req        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant             <= w_gnt;
            r_owner             <= w_idx;
            r_dma_start         <= 1'b1;
            r_req.addr          <= DMA_ADDR_W'(bus.req_addr[w_idx]);
            r_req.offset        <= DMA_ADDR_W'(bus.req_offset[w_idx]);
            r_req.mode          <= dma_mode_e'(bus.req_mode[w_idx]);
            r_req.filter_number <= DMA_ADDR_W'(bus.req_filter_number[w_idx]);
            r_req.wdata         <= DMA_DATA_W'(bus.req_wdata[w_idx]);
            r_state             <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.dma_finish) begin
            r_dma_start  <= 1'b0;
            r_req_finish <= r_grant;
            r_state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!bus.req_start[r_owner]) begin
            r_req_finish <= '0;
            r_grant      <= '0;
            r_last       <= r_owner;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant                      = r_grant;
  assign bus.req_finish                 = r_req_finish;
  assign bus.dma_start                  = r_dma_start;
  assign bus.dma_start_address          = r_req.addr;
  assign bus.dma_offset                 = r_req.offset;
  assign bus.dma_filter_number          = r_req.filter_number;
  assign bus.dma_read_write_filter_bias = 2'(r_req.mode);
  assign bus.dma_input_data             = r_req.wdata;

endmodule
